// File: rtl/pwm_channel_pkg.sv
// Shared definitions for the single-channel PWM generator.
package pwm_channel_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int unsigned PWM_WIDTH_DEFAULT  = 32;
  localparam int unsigned PWM_PERIOD_DEFAULT = 256;

endpackage

// File: rtl/pwm_channel.sv
// Single-channel PWM generator with double-buffered duty/period.
// Updates, start and stop all take effect on a period boundary.
module pwm_channel
  import pwm_channel_pkg::*;
#(
  parameter int unsigned WIDTH       = PWM_WIDTH_DEFAULT,
  parameter bit          IDLE_LEVEL  = 1'b0,
  parameter bit          ACTIVE_HIGH = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             upd_valid,
  input  logic [WIDTH-1:0] duty,
  input  logic [WIDTH-1:0] period,
  output logic             upd_ack,
  output logic             period_end,
  output logic             running,
  output logic             pwm_out
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] duty_act_q, duty_act_d;
  logic [WIDTH-1:0] period_act_q, period_act_d;
  logic [WIDTH-1:0] duty_sh_q, duty_sh_d;
  logic [WIDTH-1:0] period_sh_q, period_sh_d;
  logic             pending_q, pending_d;

  logic             pwm_q, pwm_d;
  logic             period_end_q, period_end_d;
  logic             upd_ack_q, upd_ack_d;
  logic             running_q, running_d;

  logic             wrap;
  logic             xfer;

  // State, counter, active and shadow registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      duty_act_q   <= '0;
      period_act_q <= '0;
      duty_sh_q    <= '0;
      period_sh_q  <= '0;
      pending_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      duty_act_q   <= duty_act_d;
      period_act_q <= period_act_d;
      duty_sh_q    <= duty_sh_d;
      period_sh_q  <= period_sh_d;
      pending_q    <= pending_d;
    end
  end

  // Next state: shadow capture, boundary transfer and run/stop decisions.
  // An update arriving on a load point bypasses the shadow so it applies at once.
  always_comb begin
    wrap         = (state_q == ST_RUN) && (cnt_q == period_act_q - ONE);
    xfer         = ((state_q == ST_IDLE) || wrap) && (pending_q || upd_valid);
    state_d      = state_q;
    cnt_d        = cnt_q;
    duty_act_d   = duty_act_q;
    period_act_d = period_act_q;
    duty_sh_d    = duty_sh_q;
    period_sh_d  = period_sh_q;
    pending_d    = pending_q;

    if (upd_valid) begin
      duty_sh_d   = duty;
      period_sh_d = period;
      pending_d   = 1'b1;
    end

    if (xfer) begin
      duty_act_d   = upd_valid ? duty   : duty_sh_q;
      period_act_d = upd_valid ? period : period_sh_q;
      pending_d    = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (en && (period_act_d != '0)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (wrap) begin
          cnt_d = '0;
          if (!en || (period_act_d == '0)) begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode: compare level, boundary pulse and transfer acknowledge.
  always_comb begin
    running_d    = (state_q == ST_RUN);
    pwm_d        = running_d ? ((cnt_q < duty_act_q) ^ !ACTIVE_HIGH) : IDLE_LEVEL;
    period_end_d = wrap;
    upd_ack_d    = xfer;
  end

  // Registered output stage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pwm_q        <= IDLE_LEVEL;
      period_end_q <= 1'b0;
      upd_ack_q    <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      pwm_q        <= pwm_d;
      period_end_q <= period_end_d;
      upd_ack_q    <= upd_ack_d;
      running_q    <= running_d;
    end
  end

  assign pwm_out    = pwm_q;
  assign period_end = period_end_q;
  assign upd_ack    = upd_ack_q;
  assign running    = running_q;

endmodule

// File: tb/tb_pwm_channel.sv
// Self-checking bench for pwm_channel: vector table, directed sequences
// and randomized traffic against a period-level reference model.
module tb_pwm_channel;

  localparam int unsigned W   = 32;
  localparam bit          IDL = 1'b0;
  localparam bit          AH  = 1'b1;

  logic         clk;
  logic         rst;
  logic         en;
  logic         upd_valid;
  logic [W-1:0] duty;
  logic [W-1:0] period;
  logic         upd_ack;
  logic         period_end;
  logic         running;
  logic         pwm_out;

  pwm_channel #(
    .WIDTH(W),
    .IDLE_LEVEL(IDL),
    .ACTIVE_HIGH(AH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .upd_valid(upd_valid),
    .duty(duty),
    .period(period),
    .upd_ack(upd_ack),
    .period_end(period_end),
    .running(running),
    .pwm_out(pwm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: whether a period is in progress, position inside it,
  // values in force for this period, and a mailbox for the next period.
  bit     m_run = 0;
  longint m_pos = 0;
  longint m_duty = 0, m_per = 0;
  longint m_nx_duty = 0, m_nx_per = 0;
  bit     m_has_next = 0;

  // Accumulators for per-period measurements.
  int g_hi = 0, g_len = 0, g_ack = 0, g_ackpe = 0;

  typedef struct {
    bit          rst_n;
    bit          en;
    bit          upd;
    int unsigned duty;
    int unsigned period;
    bit          pwm;
    bit          pe;
    bit          run;
    bit          ack;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: predict outputs from the model, advance the DUT, compare.
  task automatic tick();
    bit     e_pwm, e_pe, e_run, e_ack;
    bit     last_cnt;
    if (!rst) begin
      e_pwm = IDL; e_pe = 0; e_run = 0; e_ack = 0;
      m_run = 0; m_pos = 0; m_duty = 0; m_per = 0;
      m_nx_duty = 0; m_nx_per = 0; m_has_next = 0;
    end else begin
      last_cnt = m_run && (m_pos == m_per - 1);
      e_run    = m_run;
      e_pe     = last_cnt;
      e_pwm    = m_run ? ((m_pos < m_duty) ? AH : !AH) : IDL;
      if (upd_valid) begin
        m_nx_duty  = longint'(duty);
        m_nx_per   = longint'(period);
        m_has_next = 1;
      end
      e_ack = (!m_run || last_cnt) && m_has_next;
      if (e_ack) begin
        m_duty = m_nx_duty;
        m_per  = m_nx_per;
        m_has_next = 0;
      end
      if (!m_run) begin
        if (en && m_per != 0) begin
          m_run = 1;
          m_pos = 0;
        end
      end else if (last_cnt) begin
        m_pos = 0;
        if (!en || m_per == 0) m_run = 0;
      end else begin
        m_pos++;
      end
    end
    @(posedge clk);
    #1;
    chk("model pwm_out", pwm_out, e_pwm);
    chk("model period_end", period_end, e_pe);
    chk("model running", running, e_run);
    chk("model upd_ack", upd_ack, e_ack);
    g_len++;
    if (pwm_out == AH) g_hi++;
    if (upd_ack) g_ack++;
    if (upd_ack && period_end) g_ackpe++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr_acc();
    g_hi = 0; g_len = 0; g_ack = 0; g_ackpe = 0;
  endtask

  // Run until the next period_end pulse, bounded.
  task automatic wait_pe(output int hi, output int len, output int ack, output int ackpe);
    bit seen;
    seen = 0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (period_end) begin
        seen = 1;
        break;
      end
    end
    if (!seen) chk("period_end timeout", 0, 1);
    hi = g_hi; len = g_len; ack = g_ack; ackpe = g_ackpe;
    clr_acc();
  endtask

  task automatic apply_upd(input int unsigned d, input int unsigned p);
    upd_valid = 1; duty = d; period = p;
    tick();
    upd_valid = 0;
  endtask

  initial begin
    int hi, len, ack, ackpe;
    rst = 0; en = 0; upd_valid = 0; duty = '0; period = '0;

    //            rst en upd duty per  pwm pe run ack
    tbl[0]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0};
    tbl[1]  = '{1, 0, 1, 1, 3,  0, 0, 0, 1};
    tbl[2]  = '{1, 1, 0, 0, 0,  0, 0, 0, 0};
    tbl[3]  = '{1, 1, 0, 0, 0,  1, 0, 1, 0};
    tbl[4]  = '{1, 1, 0, 0, 0,  0, 0, 1, 0};
    tbl[5]  = '{1, 0, 0, 0, 0,  0, 1, 1, 0};
    tbl[6]  = '{1, 1, 1, 3, 2,  0, 0, 0, 1};
    tbl[7]  = '{1, 1, 0, 0, 0,  1, 0, 1, 0};
    tbl[8]  = '{1, 1, 1, 0, 0,  1, 1, 1, 1};
    tbl[9]  = '{1, 1, 0, 0, 0,  0, 0, 0, 0};
    tbl[10] = '{1, 1, 0, 0, 0,  0, 0, 0, 0};

    for (int i = 0; i < 11; i++) begin
      rst = tbl[i].rst_n; en = tbl[i].en; upd_valid = tbl[i].upd;
      duty = tbl[i].duty; period = tbl[i].period;
      tick();
      chk($sformatf("tbl[%0d] pwm_out", i), pwm_out, tbl[i].pwm);
      chk($sformatf("tbl[%0d] period_end", i), period_end, tbl[i].pe);
      chk($sformatf("tbl[%0d] running", i), running, tbl[i].run);
      chk($sformatf("tbl[%0d] upd_ack", i), upd_ack, tbl[i].ack);
    end
    upd_valid = 0;

    // Basic waveform 64/256.
    rst = 0; en = 0; tick(); rst = 1;
    apply_upd(64, 256);
    en = 1;
    clr_acc();
    wait_pe(hi, len, ack, ackpe);
    chk("basic first hi", hi, 64);
    chk("basic first ack", ack, 0);
    wait_pe(hi, len, ack, ackpe);
    chk("basic hi", hi, 64);
    chk("basic len", len, 256);
    chk("basic no ack", ack, 0);

    // Mid-period update at cnt=10.
    ticks(10);
    apply_upd(200, 256);
    wait_pe(hi, len, ack, ackpe);
    chk("mid cur hi", hi, 64);
    chk("mid cur len", len, 256);
    chk("mid ack", ack, 1);
    chk("mid ack with period_end", ackpe, 1);
    wait_pe(hi, len, ack, ackpe);
    chk("mid next hi", hi, 200);

    // Last-wins shadow.
    ticks(5);
    apply_upd(32, 256);
    ticks(20);
    apply_upd(128, 256);
    wait_pe(hi, len, ack, ackpe);
    chk("lastwin cur hi", hi, 200);
    chk("lastwin one ack", ack, 1);
    wait_pe(hi, len, ack, ackpe);
    chk("lastwin next hi", hi, 128);
    chk("lastwin no ack", ack, 0);

    // Duty extremes.
    apply_upd(0, 256);
    wait_pe(hi, len, ack, ackpe);
    wait_pe(hi, len, ack, ackpe);
    chk("duty0 hi", hi, 0);
    apply_upd(300, 256);
    wait_pe(hi, len, ack, ackpe);
    wait_pe(hi, len, ack, ackpe);
    chk("duty300 hi", hi, 256);
    apply_upd(255, 256);
    wait_pe(hi, len, ack, ackpe);
    wait_pe(hi, len, ack, ackpe);
    chk("duty255 hi", hi, 255);
    chk("duty255 len", len, 256);

    // Drop en at cnt=100.
    ticks(100);
    en = 0;
    wait_pe(hi, len, ack, ackpe);
    chk("stop hi", hi, 255);
    chk("stop len", len, 256);
    tick();
    chk("stop running", running, 0);
    chk("stop pwm idle", pwm_out, IDL);

    // period=0 update stops at the boundary.
    en = 1;
    apply_upd(10, 8);
    wait_pe(hi, len, ack, ackpe);
    apply_upd(3, 0);
    wait_pe(hi, len, ack, ackpe);
    chk("p0 hi", hi, 8);
    chk("p0 ack", ack, 1);
    tick();
    chk("p0 running", running, 0);
    ticks(3);
    chk("p0 stays idle", running, 0);

    // Reset at cnt=50 with a pending shadow update.
    apply_upd(20, 64);
    wait_pe(hi, len, ack, ackpe);
    ticks(40);
    apply_upd(5, 16);
    ticks(9);
    rst = 0;
    tick();
    chk("rst pwm", pwm_out, IDL);
    chk("rst period_end", period_end, 0);
    chk("rst running", running, 0);
    chk("rst upd_ack", upd_ack, 0);
    rst = 1;
    clr_acc();
    ticks(20);
    chk("rst shadow discarded ack", g_ack, 0);
    chk("rst shadow discarded run", running, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) != 0);
      en        = ($urandom_range(0, 9) != 0);
      upd_valid = ($urandom_range(0, 7) == 0);
      duty      = $urandom_range(0, 10);
      period    = $urandom_range(0, 8);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
